// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: default widths,
// the ALU operation code type and the sequencer FSM state encoding.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // Operation code, passed unchanged to ALU_Sel
  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD = 3'b000;
  localparam alu_op_t ALU_OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command front-end for the combinational ALU. Registers
// operands towards the ALU on acceptance, captures the ALU result one
// cycle later, and holds it on a valid/ready response port. Keeps an
// accumulator for chained operations and a completed-response counter.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t state;
  seq_state_t state_next;

  logic cmd_fire;
  logic res_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign res_fire = res_valid && res_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (cmd_fire) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (res_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only; res_ready never reaches cmd_ready
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RESP: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand registers towards the ALU, loaded only on command acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (cmd_fire) begin
      alu_a   <= cmd_use_acc ? acc : cmd_a;
      alu_b   <= cmd_b;
      alu_sel <= cmd_op;
    end
  end

  // Result capture at the end of EXEC; held through RESP until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_zero <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_data <= alu_out;
      res_zero <= alu_zero;
    end
  end

  // Accumulator: clear takes priority over the EXEC capture
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (state == ST_EXEC) begin
      acc <= alu_out;
    end
  end

  // Completed-response counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (res_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer. Two instances share the same
// stimulus: the default one (CNT_W=16) and a CNT_W=2 one for counter wrap.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic       acc_clr;
  logic       res_ready;

  logic        d_cmd_ready, d_res_valid, d_res_zero, d_alu_zero;
  logic [7:0]  d_alu_a, d_alu_b, d_alu_out, d_res_data, d_acc;
  logic [2:0]  d_alu_sel;
  logic [15:0] d_op_count;

  logic        s_cmd_ready, s_res_valid, s_res_zero, s_alu_zero;
  logic [7:0]  s_alu_a, s_alu_b, s_alu_out, s_res_data, s_acc;
  logic [2:0]  s_alu_sel;
  logic [1:0]  s_op_count;

  int n_cmp = 0;
  int n_err = 0;
  int mcnt  = 0;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic [7:0] acc;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  // Bench ALU model: 000 = A+B, 001 = A-B, a few logic ops otherwise
  function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a,
                                       input logic [7:0] b);
    case (sel)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      default: return a;
    endcase
  endfunction

  assign d_alu_out  = alu_f(d_alu_sel, d_alu_a, d_alu_b);
  assign d_alu_zero = (d_alu_out == 8'h00);
  assign s_alu_out  = alu_f(s_alu_sel, s_alu_a, s_alu_b);
  assign s_alu_zero = (s_alu_out == 8'h00);

  alu_cmd_sequencer #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d_cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .acc_clr(acc_clr), .alu_a(d_alu_a), .alu_b(d_alu_b), .alu_sel(d_alu_sel),
    .alu_out(d_alu_out), .alu_zero(d_alu_zero), .res_valid(d_res_valid),
    .res_ready(res_ready), .res_data(d_res_data), .res_zero(d_res_zero),
    .acc(d_acc), .op_count(d_op_count)
  );

  alu_cmd_sequencer #(.WIDTH(8), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .acc_clr(acc_clr), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel),
    .alu_out(s_alu_out), .alu_zero(s_alu_zero), .res_valid(s_res_valid),
    .res_ready(res_ready), .res_data(s_res_data), .res_zero(s_res_zero),
    .acc(s_acc), .op_count(s_op_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      mcnt = 0;
    end else if (d_res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got res_data 0x%0h with empty scoreboard", d_res_data);
      end else begin
        e = sbq.pop_front();
        chk("res_data", d_res_data, e.data);
        chk("res_zero", d_res_zero, e.zero);
        chk("acc_at_resp", d_acc, e.acc);
        chk("res_data_w2", s_res_data, e.data);
      end
      chk("op_count", d_op_count, mcnt);
      chk("op_count_w2", s_op_count, mcnt % 4);
      chk("res_valid_w2", s_res_valid, 1);
      mcnt++;
    end
  end

  // clr: 0 none, 1 acc_clr in accept cycle, 2 acc_clr in EXEC cycle
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic use_acc, input int clr, input bit lat,
                      input logic [7:0] exp_data, input logic exp_zero,
                      input logic [7:0] exp_acc);
    bit ok;
    exp_t e;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    cmd_valid = 1'b1;
    if (clr == 1) acc_clr = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = d_cmd_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
    acc_clr = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got cmd_ready 0 expected 1 within 50 cycles");
      return;
    end
    e.data = exp_data; e.zero = exp_zero; e.acc = exp_acc;
    sbq.push_back(e);
    chk("alu_b", d_alu_b, b);
    chk("alu_sel", d_alu_sel, op);
    if (lat) chk("res_valid_exec", d_res_valid, 0);
    if (clr == 2) acc_clr = 1'b1;
    if (lat || clr == 2) begin
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
    end
    if (lat) chk("res_valid_latency", d_res_valid, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sbq.size() == 0 && !d_res_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", d_cmd_ready, 1);
    chk("rst_res_valid", d_res_valid, 0);
    chk("rst_res_data", d_res_data, 0);
    chk("rst_acc", d_acc, 0);
    chk("rst_op_count", d_op_count, 0);
    chk("rst_alu_a", d_alu_a, 0);
    chk("rst_alu_sel", d_alu_sel, 0);

    // Single op with latency check
    res_ready = 1'b1;
    send(3'b000, 8'h05, 8'h03, 1'b0, 0, 1'b1, 8'h08, 1'b0, 8'h08);
    drain();
    chk("single_op_count", d_op_count, 1);
    chk("single_acc", d_acc, 8'h08);

    // Accumulator chain: 5+3 = 8, then acc-8 = 0
    send(3'b000, 8'h05, 8'h03, 1'b0, 0, 1'b0, 8'h08, 1'b0, 8'h08);
    send(3'b001, 8'hFF, 8'h08, 1'b1, 0, 1'b0, 8'h00, 1'b1, 8'h00);
    drain();
    chk("chain_acc", d_acc, 8'h00);
    chk("chain_alu_a", d_alu_a, 8'h08);

    // Clear in accept cycle: operand A is the old acc (8), so 8+1 = 9
    send(3'b000, 8'h05, 8'h03, 1'b0, 0, 1'b0, 8'h08, 1'b0, 8'h08);
    drain();
    send(3'b000, 8'hAA, 8'h01, 1'b1, 1, 1'b0, 8'h09, 1'b0, 8'h09);
    drain();

    // Clear collides with EXEC capture: res 2+4 = 6, acc forced to 0
    send(3'b000, 8'h02, 8'h04, 1'b0, 2, 1'b0, 8'h06, 1'b0, 8'h00);
    drain();
    chk("collision_acc", d_acc, 8'h00);

    // Backpressure with a second command held on the input
    res_ready = 1'b0;
    send(3'b000, 8'h10, 8'h20, 1'b0, 0, 1'b0, 8'h30, 1'b0, 8'h30);
    cmd_op = 3'b001; cmd_a = 8'h07; cmd_b = 8'h02; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", d_res_valid, 1);
      chk("bp_res_data", d_res_data, 8'h30);
      chk("bp_res_zero", d_res_zero, 0);
      chk("bp_cmd_ready", d_cmd_ready, 0);
      chk("bp_alu_a", d_alu_a, 8'h10);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    chk("bp_cmd_ready_hs", d_cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("bp_idle_ready", d_cmd_ready, 1);
    chk("bp_not_yet_accepted", d_alu_a, 8'h10);
    send(3'b001, 8'h07, 8'h02, 1'b0, 0, 1'b0, 8'h05, 1'b0, 8'h05);
    drain();
    chk("bp_op_count", d_op_count, 8);

    // Reset while a response is pending
    res_ready = 1'b0;
    send(3'b000, 8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0, 8'h02);
    @(posedge clk);
    #1;
    chk("pre_rst_res_valid", d_res_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_res_valid", d_res_valid, 0);
    chk("midrst_cmd_ready", d_cmd_ready, 1);
    chk("midrst_acc", d_acc, 0);
    chk("midrst_op_count", d_op_count, 0);
    chk("midrst_op_count_w2", s_op_count, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_res_valid", d_res_valid, 0);

    // Counter wrap on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      send(3'b000, 8'(i + 1), 8'h01, 1'b0, 0, 1'b0, 8'(i + 2), 1'b0, 8'(i + 2));
      drain();
      chk("wrap_op_count_w2", s_op_count, wrap_exp[i]);
    end
    chk("wrap_op_count", d_op_count, 5);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
